vector_streamer: RTL and testbench

VECTOR_STREAMER -- requirements
Module: vector_streamer

---
 rtl/vector_streamer.sv | 110 +++++++++++
 tb/tb_vector_streamer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_streamer.sv
// Vector pair streamer: queues A/B byte-vector pairs and replays them as 6-slot frames
// to a dot-product unit, capturing the unit's result one frame later.
module vector_streamer (
    input  logic        clk,
    input  logic        resetn,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [23:0] s_a,
    input  logic [23:0] s_b,
    output logic [7:0]  m_data,
    output logic [2:0]  m_slot,
    output logic        m_real,
    input  logic [17:0] res_in,
    output logic [17:0] r_data,
    output logic        r_valid
);

    // Handshake: a pair transfers on a rising edge where s_valid && s_ready; s_ready
    // depends only on FIFO occupancy (never on s_valid) and is low throughout reset.

    logic [2:0]  slot;
    logic [47:0] mem [2];
    logic        rd_ptr, wr_ptr;
    logic [1:0]  count, count_nxt;
    logic [47:0] frame_reg, frame_nxt;
    logic        m_real_q, last_real;
    logic [17:0] r_data_q;
    logic        r_valid_q;

    logic push, frame_end, pop_fifo, bypass, wr_en;

    assign s_ready   = resetn && (count != 2'd2);
    assign push      = s_valid && s_ready;
    assign frame_end = (slot == 3'd5);
    assign pop_fifo  = frame_end && (count != 2'd0);
    // An empty FIFO at the frame boundary forwards a same-edge push straight into the frame.
    assign bypass    = frame_end && (count == 2'd0) && push;
    assign wr_en     = push && !bypass;

    always_comb begin
        count_nxt = count;
        case ({wr_en, pop_fifo})
            2'b10:   count_nxt = count + 2'd1;
            2'b01:   count_nxt = count - 2'd1;
            default: count_nxt = count;
        endcase
    end

    always_comb begin
        frame_nxt = 48'd0;
        if (pop_fifo)
            frame_nxt = mem[rd_ptr];
        else if (bypass)
            frame_nxt = {s_b, s_a};
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= {s_b, s_a};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            slot      <= 3'd0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            count     <= 2'd0;
            frame_reg <= 48'd0;
            m_real_q  <= 1'b0;
            last_real <= 1'b0;
            r_data_q  <= 18'd0;
            r_valid_q <= 1'b0;
        end else begin
            slot  <= frame_end ? 3'd0 : slot + 3'd1;
            count <= count_nxt;
            if (wr_en)
                wr_ptr <= ~wr_ptr;
            if (pop_fifo)
                rd_ptr <= ~rd_ptr;
            if (frame_end) begin
                frame_reg <= frame_nxt;
                m_real_q  <= pop_fifo || bypass;
                last_real <= m_real_q;
            end
            // The consumer's result for the frame that just ended is valid during slot 0.
            r_valid_q <= (slot == 3'd0) && last_real;
            if ((slot == 3'd0) && last_real)
                r_data_q <= res_in;
        end
    end

    always_comb begin
        m_data = 8'd0;
        case (slot)
            3'd0:    m_data = frame_reg[7:0];
            3'd1:    m_data = frame_reg[15:8];
            3'd2:    m_data = frame_reg[23:16];
            3'd3:    m_data = frame_reg[31:24];
            3'd4:    m_data = frame_reg[39:32];
            3'd5:    m_data = frame_reg[47:40];
            default: m_data = 8'd0;
        endcase
    end

    assign m_slot  = slot;
    assign m_real  = m_real_q;
    assign r_data  = r_data_q;
    assign r_valid = r_valid_q;

endmodule

// File: tb/tb_vector_streamer.sv
// Bench for vector_streamer: randomized pairs, a behavioural dot-product consumer,
// and a frame/result scoreboard fed from the accepted-pair queue.
module tb_vector_streamer;
  logic        clk = 1'b0;
  logic        resetn;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] s_a, s_b;
  logic [7:0]  m_data;
  logic [2:0]  m_slot;
  logic        m_real;
  logic [17:0] res_in;
  logic [17:0] r_data;
  logic        r_valid;

  int n_vec = 0;
  int n_err = 0;
  int rv_cnt = 0;

  logic [47:0] exp_q[$];
  logic [2:0]  tb_slot;
  logic [47:0] cons_f = 48'd0;

  logic [47:0] cur_frame;
  logic        cur_real;
  logic        pend_real;
  logic [17:0] pend_dot;
  logic [17:0] r_hold;

  vector_streamer dut (
    .clk     (clk),
    .resetn  (resetn),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_a     (s_a),
    .s_b     (s_b),
    .m_data  (m_data),
    .m_slot  (m_slot),
    .m_real  (m_real),
    .res_in  (res_in),
    .r_data  (r_data),
    .r_valid (r_valid)
  );

  // clock / reset
  always #5 clk = ~clk;

  // consumer's own 6-slot counter, reset together with the streamer
  always @(posedge clk or negedge resetn) begin
    if (!resetn) tb_slot <= 3'd0;
    else         tb_slot <= (tb_slot == 3'd5) ? 3'd0 : tb_slot + 3'd1;
  end

  function automatic logic [17:0] dot(input logic [47:0] f);
    int s = 0;
    for (int k = 0; k < 3; k++) s += int'(f[8*k +: 8]) * int'(f[24 + 8*k +: 8]);
    return 18'(s);
  endfunction

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // behavioural dot-product unit: collects a frame, presents its result in the next slot 0
  always @(negedge clk) begin
    int idx;
    idx = int'(tb_slot);
    if (tb_slot == 3'd0) res_in = dot(cons_f);
    else                 res_in = 18'($urandom_range(0, 262143));
    cons_f[idx*8 +: 8] = m_data;
  end

  // monitor: each frame takes the oldest accepted pair not yet framed, else idle
  always @(negedge clk) begin
    int idx;
    if (!resetn) begin
      cur_frame = 48'd0;
      cur_real  = 1'b0;
      pend_real = 1'b0;
      pend_dot  = 18'd0;
      r_hold    = 18'd0;
    end else begin
      if (tb_slot == 3'd0) begin
        pend_real = cur_real;
        pend_dot  = dot(cur_frame);
        if (exp_q.size() > 0) begin
          cur_frame = exp_q.pop_front();
          cur_real  = 1'b1;
        end else begin
          cur_frame = 48'd0;
          cur_real  = 1'b0;
        end
      end
      idx = int'(tb_slot);
      check("m_slot", m_slot, tb_slot);
      check("m_real", m_real, cur_real);
      check("m_data", m_data, cur_frame[idx*8 +: 8]);
      if (tb_slot == 3'd1) begin
        check("r_valid_slot1", r_valid, pend_real);
        if (pend_real) r_hold = pend_dot;
      end else begin
        check("r_valid_other", r_valid, 1'b0);
      end
      if (r_valid) rv_cnt++;
      check("r_data", r_data, r_hold);
    end
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      s_valid = 1'b0;
      s_a = 24'($urandom);
      s_b = 24'($urandom);
    end
  endtask

  task automatic send(input logic [23:0] a, input logic [23:0] b);
    int t = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_a = a;
    s_b = b;
    #1;
    while (!s_ready) begin
      if (t >= 60) begin
        n_vec++;
        n_err++;
        $display("FAIL send_timeout: got s_ready=0 expected 1 within 60 cycles");
        s_valid = 1'b0;
        return;
      end
      @(negedge clk);
      #1;
      t++;
    end
    @(posedge clk);
    exp_q.push_back({b, a});
  endtask

  task automatic wait_slot(input logic [2:0] s);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (tb_slot != s && t < 20);
  endtask

  initial begin
    int rv_before;
    int t;
    resetn = 1'b0;
    s_valid = 1'b0;
    s_a = 24'd0;
    s_b = 24'd0;
    res_in = 18'd0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_m_slot", m_slot, 3'd0);
    check("rst_m_real", m_real, 1'b0);
    check("rst_m_data", m_data, 8'd0);
    check("rst_r_valid", r_valid, 1'b0);
    check("rst_r_data", r_data, 18'd0);
    #1 resetn = 1'b1;
    #1;
    check("s_ready_after_rst", s_ready, 1'b1);

    // single pair (1,2,3).(4,5,6) = 32
    send({8'd3, 8'd2, 8'd1}, {8'd6, 8'd5, 8'd4});
    idle(18);
    check("single_r_data", r_data, 18'd32);

    // three idle frames: no pulses
    rv_before = rv_cnt;
    idle(18);
    check("idle_no_r_valid", rv_cnt, rv_before);

    // back-to-back: full after two accepts, third waits for the slot-5 pop
    wait_slot(3'd5);
    send(24'h030201, 24'h010101);
    send(24'h0a0b0c, 24'h020202);
    @(negedge clk);
    #1;
    check("b2b_full_s_ready", s_ready, 1'b0);
    send(24'h111111, 24'h222222);
    rv_before = rv_cnt;
    idle(30);
    check("b2b_three_pulses", rv_cnt - rv_before, 3);

    // maximum values
    send(24'hffffff, 24'hffffff);
    idle(20);
    check("max_r_data", r_data, 18'd195075);

    // reset at slot 3 of a real frame with one pair still queued
    wait_slot(3'd5);
    send(24'h050505, 24'h060606);
    send(24'h070707, 24'h080808);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(m_real && tb_slot == 3'd3) && t < 30);
    check("rst_mid_reached", tb_slot, 3'd3);
    #2 resetn = 1'b0;
    s_valid = 1'b0;
    #1;
    check("midrst_m_data", m_data, 8'd0);
    check("midrst_m_real", m_real, 1'b0);
    check("midrst_m_slot", m_slot, 3'd0);
    check("midrst_s_ready", s_ready, 1'b0);
    check("midrst_r_valid", r_valid, 1'b0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #2 resetn = 1'b1;
    #1;
    check("post_rst_slot", m_slot, 3'd0);
    check("post_rst_real", m_real, 1'b0);
    rv_before = rv_cnt;
    idle(20);
    check("lost_pairs_no_r_valid", rv_cnt, rv_before);

    // randomized pairs with random gaps
    for (int i = 0; i < 60; i++) begin
      idle($urandom_range(0, 3));
      send(24'($urandom), 24'($urandom));
    end
    idle(30);
    check("drain_exp_q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
